uart_time_sender: RTL
=====================

Name: uart_time_sender

Overview:
- Transmit-side message formatter for the UART watch. On request, it snapshots the current hour, minute and second and converts them to ASCII "HH:MM:SS" plus an end-of-line character.
- It feeds the bytes one at a time to the byte-level UART transmitter using a start/busy handshake.
- It sits between the watch time counters and the UART transmitter, and is the outbound counterpart of the receive-side command path.

Parameters:
- SEP_CHAR, 8'h3A, separator byte placed between fields (':').
- EOL_CHAR, 8'h0A, final byte of each message (LF).

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous active-high reset
- send_req  input  1  request to send one time message; sampled only in IDLE
- hour  input  5  current hour, 0..23
- min  input  6  current minute, 0..59
- sec  input  6  current second, 0..59
- tx_busy  input  1  byte transmitter busy; high from shortly after tx_start until the stop bit completes
- tx_start  output  1  one-cycle pulse; byte valid on tx_data
- tx_data  output  8  byte to transmit; held stable from tx_start until the byte completes
- busy  output  1  high from the cycle after send_req is accepted until done
- done  output  1  one-cycle pulse after the last byte completes

Behaviour:
- Reset values: all outputs 0; state IDLE; byte index 0; snapshot registers 0.
- Reset is asynchronous. Asserting reset mid-message aborts at once, and no further tx_start is issued.
- Accepting a request:
  - IDLE plus send_req=1 captures hour, min and sec into snapshot registers on that edge and moves to LOAD.
  - send_req is ignored in every other state. It is not queued.
- Saturation: snapshot values above range are clamped: hour>23 becomes 23, min>59 becomes 59, sec>59 becomes 59.
- BCD conversion: each field becomes a tens and a ones digit by comparison/subtraction (no divider). Each digit is ASCII-encoded as 8'h30 + digit.
- Message byte order (index 0..8): H tens, H ones, SEP, M tens, M ones, SEP, S tens, S ones, EOL. That is 9 bytes.
- FSM states: IDLE, LOAD, START, WAIT_ACK, WAIT_DONE, FINISH.
  - LOAD: compute the digits and set the byte index to 0. Next state is START.
  - START:
    - If tx_busy=1, stay in START with tx_start=0.
    - Otherwise drive tx_data with byte[index] and pulse tx_start for exactly 1 cycle, then go to WAIT_ACK.
  - WAIT_ACK: wait for tx_busy=1, then go to WAIT_DONE. tx_start must not be re-pulsed.
  - WAIT_DONE: wait for tx_busy=0.
    - If index=last, go to FINISH.
    - Otherwise increment the index and go to START.
  - FINISH: pulse done for 1 cycle, then go to IDLE.
- busy: 1 in every state except IDLE.
- Minimum spacing between consecutive tx_start pulses is 3 cycles, even with a zero-latency transmitter.
- A new send_req in the same cycle that done is pulsed is ignored, because the FSM is not yet in IDLE. A request one cycle later is accepted.
- tx_data is a registered output and does not change while in WAIT_ACK or WAIT_DONE.
- Input changes to hour, min and sec during a message do not affect the message in progress.

Optional Feature:
- Macro: UART_TIME_CRLF_EN.
- Defined: the message ends with 8'h0D then EOL_CHAR, giving 10 bytes (index 0..9).
- Undefined: the message ends with EOL_CHAR only, giving 9 bytes.
- busy, done and the handshake are otherwise identical in both builds.

Test Plan:
- hour=12, min=34, sec=56, send_req pulse, transmitter model with busy lasting 20 cycles -> tx_data sequence 31 32 3A 33 34 3A 35 36 0A. Exactly 9 tx_start pulses, then one done pulse, and busy falls with done's final cycle.
- hour=0, min=0, sec=0 -> 30 30 3A 30 30 3A 30 30 0A. With UART_TIME_CRLF_EN defined, the sequence ends 0D 0A and there are 10 pulses.
- hour=31, min=63, sec=60 (saturation) -> 32 33 3A 35 39 3A 35 39 0A ("23:59:59").
- Repeat send_req every cycle during a message, and change hour mid-message -> no extra messages, bytes match the snapshot, and a second request issued 1 cycle after done yields a second full message.
- Hold tx_busy=1 before the first byte -> tx_start stays 0 until tx_busy=0, then a single pulse. A tx_busy that rises 5 cycles late gets no duplicate tx_start.
- Assert reset during WAIT_DONE of byte 4 -> tx_start, busy and done go to 0 immediately, and no tx_start occurs after release until a new send_req.

Source files
------------

// File: rtl/uart_time_sender.sv
// Snapshots hour/min/sec and sends "HH:MM:SS" plus end-of-line, one byte per start/busy handshake.
// Build macro UART_TIME_CRLF_EN inserts a CR (8'h0D) before the end-of-line byte.
module uart_time_sender #(
  parameter logic [7:0] SEP_CHAR = 8'h3A,
  parameter logic [7:0] EOL_CHAR = 8'h0A
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       send_req,
  input  logic [4:0] hour,
  input  logic [5:0] min,
  input  logic [5:0] sec,
  input  logic       tx_busy,
  output logic       tx_start,
  output logic [7:0] tx_data,
  output logic       busy,
  output logic       done
);

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] LOAD      = 3'd1;
  localparam logic [2:0] START     = 3'd2;
  localparam logic [2:0] WAIT_ACK  = 3'd3;
  localparam logic [2:0] WAIT_DONE = 3'd4;
  localparam logic [2:0] FINISH    = 3'd5;

`ifdef UART_TIME_CRLF_EN
  localparam logic [3:0] LAST_IDX = 4'd9;
`else
  localparam logic [3:0] LAST_IDX = 4'd8;
`endif

  logic [2:0] state;
  logic [3:0] idx;
  logic [4:0] snap_hour;
  logic [5:0] snap_min;
  logic [5:0] snap_sec;
  logic [7:0] h_tens, h_ones, m_tens, m_ones, s_tens, s_ones;
  logic [7:0] cur_byte;

  // Tens/ones split by comparison ladder; input is already clamped to 0..59.
  function automatic logic [15:0] to_ascii(input logic [5:0] v);
    logic [2:0] t;
    logic [5:0] r;
    if (v >= 6'd50) begin
      t = 3'd5; r = v - 6'd50;
    end else if (v >= 6'd40) begin
      t = 3'd4; r = v - 6'd40;
    end else if (v >= 6'd30) begin
      t = 3'd3; r = v - 6'd30;
    end else if (v >= 6'd20) begin
      t = 3'd2; r = v - 6'd20;
    end else if (v >= 6'd10) begin
      t = 3'd1; r = v - 6'd10;
    end else begin
      t = 3'd0; r = v;
    end
    return {8'h30 + {5'd0, t}, 8'h30 + {2'd0, r}};
  endfunction

  always_comb begin
    cur_byte = EOL_CHAR;
    case (idx)
      4'd0: cur_byte = h_tens;
      4'd1: cur_byte = h_ones;
      4'd2: cur_byte = SEP_CHAR;
      4'd3: cur_byte = m_tens;
      4'd4: cur_byte = m_ones;
      4'd5: cur_byte = SEP_CHAR;
      4'd6: cur_byte = s_tens;
      4'd7: cur_byte = s_ones;
`ifdef UART_TIME_CRLF_EN
      4'd8: cur_byte = 8'h0D;
`endif
      default: cur_byte = EOL_CHAR;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      idx       <= 4'd0;
      snap_hour <= 5'd0;
      snap_min  <= 6'd0;
      snap_sec  <= 6'd0;
      h_tens    <= 8'd0;
      h_ones    <= 8'd0;
      m_tens    <= 8'd0;
      m_ones    <= 8'd0;
      s_tens    <= 8'd0;
      s_ones    <= 8'd0;
      tx_start  <= 1'b0;
      tx_data   <= 8'd0;
    end else begin
      tx_start <= 1'b0;
      case (state)
        IDLE: begin
          if (send_req) begin
            snap_hour <= (hour > 5'd23) ? 5'd23 : hour;
            snap_min  <= (min > 6'd59) ? 6'd59 : min;
            snap_sec  <= (sec > 6'd59) ? 6'd59 : sec;
            state     <= LOAD;
          end
        end
        LOAD: begin
          {h_tens, h_ones} <= to_ascii({1'b0, snap_hour});
          {m_tens, m_ones} <= to_ascii(snap_min);
          {s_tens, s_ones} <= to_ascii(snap_sec);
          idx   <= 4'd0;
          state <= START;
        end
        START: begin
          // tx_data only ever changes here, so it is stable for the whole byte.
          if (!tx_busy) begin
            tx_start <= 1'b1;
            tx_data  <= cur_byte;
            state    <= WAIT_ACK;
          end
        end
        WAIT_ACK: begin
          if (tx_busy) state <= WAIT_DONE;
        end
        WAIT_DONE: begin
          if (!tx_busy) begin
            if (idx == LAST_IDX) begin
              state <= FINISH;
            end else begin
              idx   <= idx + 4'd1;
              state <= START;
            end
          end
        end
        FINISH:  state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign busy = (state != IDLE);
  assign done = (state == FINISH);

endmodule
